// File: rtl/sdram_client_port.sv
// rtl/sdram_client_port.sv - client command/return FIFOs in front of the SDRAM controller
module sdram_client_port #(
    parameter int ADDRESS_SIZE = 20,
    parameter int DATA_SIZE    = 16,
    parameter int WR_DEPTH     = 8,
    parameter int RD_DEPTH     = 8,
    parameter int RET_DEPTH    = 8
) (
    input  logic                         clk,
    input  logic                         i_Reset_n,
    input  logic                         i_Wr_Valid,
    output logic                         o_Wr_Ready,
    input  logic [ADDRESS_SIZE-1:0]      i_Wr_Address,
    input  logic [DATA_SIZE-1:0]         i_Wr_Data,
    input  logic                         i_Rd_Valid,
    output logic                         o_Rd_Ready,
    input  logic [ADDRESS_SIZE-1:0]      i_Rd_Address,
    output logic                         o_Rd_Data_Valid,
    input  logic                         i_Rd_Data_Ready,
    output logic [DATA_SIZE-1:0]         o_Rd_Data,
    output logic                         o_Read_Request,
    output logic [ADDRESS_SIZE-1:0]      o_Read_Address,
    input  logic                         i_Read_Grant,
    output logic                         o_Write_Request,
    output logic [ADDRESS_SIZE-1:0]      o_Write_Address,
    output logic [DATA_SIZE-1:0]         o_Write_Data,
    input  logic                         i_Write_Grant,
    input  logic                         i_Data_Valid,
    input  logic [DATA_SIZE-1:0]         i_Read_Data,
    output logic [$clog2(RET_DEPTH):0]   o_Rd_Outstanding,
    output logic                         o_Protocol_Error
);
    localparam int WPW = $clog2(WR_DEPTH);
    localparam int RPW = $clog2(RD_DEPTH);
    localparam int TPW = $clog2(RET_DEPTH);
    localparam logic [WPW:0]   WR_FULL  = (WPW+1)'(WR_DEPTH);
    localparam logic [RPW:0]   RD_FULL  = (RPW+1)'(RD_DEPTH);
    localparam logic [TPW+1:0] RET_LIM  = (TPW+2)'(RET_DEPTH);

    logic                    ready_en_q, ready_en_d;
    logic [WPW-1:0]          wr_wptr_q, wr_wptr_d, wr_rptr_q, wr_rptr_d;
    logic [WPW:0]            wr_cnt_q, wr_cnt_d;
    logic [RPW-1:0]          rd_wptr_q, rd_wptr_d, rd_rptr_q, rd_rptr_d;
    logic [RPW:0]            rd_cnt_q, rd_cnt_d;
    logic [TPW-1:0]          ret_wptr_q, ret_wptr_d, ret_rptr_q, ret_rptr_d;
    logic [TPW:0]            ret_cnt_q, ret_cnt_d;
    logic [TPW:0]            outst_q, outst_d;
    logic                    err_q, err_d;

    logic [ADDRESS_SIZE-1:0] wr_addr_mem_q [WR_DEPTH];
    logic [DATA_SIZE-1:0]    wr_data_mem_q [WR_DEPTH];
    logic [ADDRESS_SIZE-1:0] rd_addr_mem_q [RD_DEPTH];
    logic [DATA_SIZE-1:0]    ret_data_mem_q [RET_DEPTH];

    logic                    wr_push, wr_pop, rd_push, rd_pop, ret_push, ret_pop;
    logic                    hazard, credit_ok;
    logic [WPW-1:0]          wr_off;
    logic [TPW+1:0]          credit_sum;

    assign o_Wr_Ready       = ready_en_q & (wr_cnt_q != WR_FULL);
    assign o_Rd_Ready       = ready_en_q & (rd_cnt_q != RD_FULL);
    assign o_Write_Request  = (wr_cnt_q != '0);
    assign o_Write_Address  = wr_addr_mem_q[wr_rptr_q];
    assign o_Write_Data     = wr_data_mem_q[wr_rptr_q];
    assign o_Read_Address   = rd_addr_mem_q[rd_rptr_q];
    assign o_Rd_Data_Valid  = (ret_cnt_q != '0);
    assign o_Rd_Data        = ret_data_mem_q[ret_rptr_q];
    assign o_Rd_Outstanding = outst_q;
    assign o_Protocol_Error = err_q;

    assign credit_sum     = {1'b0, outst_q} + {1'b0, ret_cnt_q};
    assign credit_ok      = (credit_sum < RET_LIM);
    assign o_Read_Request = (rd_cnt_q != '0) & ~hazard & credit_ok;

    assign wr_push  = i_Wr_Valid & o_Wr_Ready;
    assign rd_push  = i_Rd_Valid & o_Rd_Ready;
    assign wr_pop   = i_Write_Grant & o_Write_Request;
    assign rd_pop   = i_Read_Grant & o_Read_Request;
    // Late data with nothing outstanding (e.g. reads lost across a reset) is dropped.
    assign ret_push = i_Data_Valid & (outst_q != '0);
    assign ret_pop  = o_Rd_Data_Valid & i_Rd_Data_Ready;

    // A read may not overtake any queued write to the same word.
    always_comb begin
        hazard = 1'b0;
        wr_off = '0;
        for (int i = 0; i < WR_DEPTH; i++) begin
            wr_off = WPW'(i) - wr_rptr_q;
            if (({1'b0, wr_off} < wr_cnt_q) && (wr_addr_mem_q[i] == o_Read_Address)) begin
                hazard = 1'b1;
            end
        end
    end

    always_comb begin
        ready_en_d = 1'b1;
        wr_wptr_d  = wr_push ? wr_wptr_q + 1'b1 : wr_wptr_q;
        wr_rptr_d  = wr_pop  ? wr_rptr_q + 1'b1 : wr_rptr_q;
        rd_wptr_d  = rd_push ? rd_wptr_q + 1'b1 : rd_wptr_q;
        rd_rptr_d  = rd_pop  ? rd_rptr_q + 1'b1 : rd_rptr_q;
        ret_wptr_d = ret_push ? ret_wptr_q + 1'b1 : ret_wptr_q;
        ret_rptr_d = ret_pop  ? ret_rptr_q + 1'b1 : ret_rptr_q;

        wr_cnt_d = wr_cnt_q;
        case ({wr_push, wr_pop})
            2'b10:   wr_cnt_d = wr_cnt_q + 1'b1;
            2'b01:   wr_cnt_d = wr_cnt_q - 1'b1;
            default: wr_cnt_d = wr_cnt_q;
        endcase

        rd_cnt_d = rd_cnt_q;
        case ({rd_push, rd_pop})
            2'b10:   rd_cnt_d = rd_cnt_q + 1'b1;
            2'b01:   rd_cnt_d = rd_cnt_q - 1'b1;
            default: rd_cnt_d = rd_cnt_q;
        endcase

        ret_cnt_d = ret_cnt_q;
        case ({ret_push, ret_pop})
            2'b10:   ret_cnt_d = ret_cnt_q + 1'b1;
            2'b01:   ret_cnt_d = ret_cnt_q - 1'b1;
            default: ret_cnt_d = ret_cnt_q;
        endcase

        outst_d = outst_q;
        case ({rd_pop, ret_push})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase

        err_d = err_q
              | (i_Write_Grant & ~o_Write_Request)
              | (i_Read_Grant & ~o_Read_Request)
              | (i_Write_Grant & i_Read_Grant)
              | (i_Data_Valid & (outst_q == '0));
    end

    always_ff @(posedge clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            ready_en_q <= 1'b0;
            wr_wptr_q  <= '0;
            wr_rptr_q  <= '0;
            wr_cnt_q   <= '0;
            rd_wptr_q  <= '0;
            rd_rptr_q  <= '0;
            rd_cnt_q   <= '0;
            ret_wptr_q <= '0;
            ret_rptr_q <= '0;
            ret_cnt_q  <= '0;
            outst_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            ready_en_q <= ready_en_d;
            wr_wptr_q  <= wr_wptr_d;
            wr_rptr_q  <= wr_rptr_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_wptr_q  <= rd_wptr_d;
            rd_rptr_q  <= rd_rptr_d;
            rd_cnt_q   <= rd_cnt_d;
            ret_wptr_q <= ret_wptr_d;
            ret_rptr_q <= ret_rptr_d;
            ret_cnt_q  <= ret_cnt_d;
            outst_q    <= outst_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_push) begin
            wr_addr_mem_q[wr_wptr_q] <= i_Wr_Address;
            wr_data_mem_q[wr_wptr_q] <= i_Wr_Data;
        end
        if (rd_push) begin
            rd_addr_mem_q[rd_wptr_q] <= i_Rd_Address;
        end
        if (ret_push) begin
            ret_data_mem_q[ret_wptr_q] <= i_Read_Data;
        end
    end
endmodule

// File: tb/tb_sdram_client_port.sv
// tb/tb_sdram_client_port.sv - directed self-checking bench for sdram_client_port
module tb_sdram_client_port;
    logic        clk = 1'b0;
    logic        i_Reset_n;
    logic        i_Wr_Valid, o_Wr_Ready;
    logic [19:0] i_Wr_Address;
    logic [15:0] i_Wr_Data;
    logic        i_Rd_Valid, o_Rd_Ready;
    logic [19:0] i_Rd_Address;
    logic        o_Rd_Data_Valid, i_Rd_Data_Ready;
    logic [15:0] o_Rd_Data;
    logic        o_Read_Request, i_Read_Grant;
    logic [19:0] o_Read_Address;
    logic        o_Write_Request, i_Write_Grant;
    logic [19:0] o_Write_Address;
    logic [15:0] o_Write_Data;
    logic        i_Data_Valid;
    logic [15:0] i_Read_Data;
    logic [3:0]  o_Rd_Outstanding;
    logic        o_Protocol_Error;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    sdram_client_port dut (
        .clk(clk), .i_Reset_n(i_Reset_n),
        .i_Wr_Valid(i_Wr_Valid), .o_Wr_Ready(o_Wr_Ready),
        .i_Wr_Address(i_Wr_Address), .i_Wr_Data(i_Wr_Data),
        .i_Rd_Valid(i_Rd_Valid), .o_Rd_Ready(o_Rd_Ready), .i_Rd_Address(i_Rd_Address),
        .o_Rd_Data_Valid(o_Rd_Data_Valid), .i_Rd_Data_Ready(i_Rd_Data_Ready), .o_Rd_Data(o_Rd_Data),
        .o_Read_Request(o_Read_Request), .o_Read_Address(o_Read_Address), .i_Read_Grant(i_Read_Grant),
        .o_Write_Request(o_Write_Request), .o_Write_Address(o_Write_Address),
        .o_Write_Data(o_Write_Data), .i_Write_Grant(i_Write_Grant),
        .i_Data_Valid(i_Data_Valid), .i_Read_Data(i_Read_Data),
        .o_Rd_Outstanding(o_Rd_Outstanding), .o_Protocol_Error(o_Protocol_Error)
    );

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    int          pushed, grants, returns, consumed;
    int          due[$];

    initial begin
        i_Reset_n = 1'b0;
        i_Wr_Valid = 1'b0; i_Wr_Address = '0; i_Wr_Data = '0;
        i_Rd_Valid = 1'b0; i_Rd_Address = '0; i_Rd_Data_Ready = 1'b0;
        i_Read_Grant = 1'b0; i_Write_Grant = 1'b0;
        i_Data_Valid = 1'b0; i_Read_Data = '0;
        @(negedge clk);
        @(negedge clk);

        // reset state
        check_vec("rst_wr_rdy", o_Wr_Ready, 0);
        check_vec("rst_rd_rdy", o_Rd_Ready, 0);
        check_vec("rst_wreq", o_Write_Request, 0);
        check_vec("rst_rreq", o_Read_Request, 0);
        check_vec("rst_rdv", o_Rd_Data_Valid, 0);
        check_vec("rst_outst", o_Rd_Outstanding, 0);
        check_vec("rst_err", o_Protocol_Error, 0);
        i_Reset_n = 1'b1;
        #1;
        check_vec("rel_wr_rdy_before_edge", o_Wr_Ready, 0);
        tick();
        check_vec("rel_wr_rdy", o_Wr_Ready, 1);
        check_vec("rel_rd_rdy", o_Rd_Ready, 1);

        // single write
        i_Wr_Valid = 1'b1; i_Wr_Address = 20'h00123; i_Wr_Data = 16'hBEEF;
        tick();
        i_Wr_Valid = 1'b0;
        check_vec("w1_req", o_Write_Request, 1);
        check_vec("w1_addr", o_Write_Address, 32'h00123);
        check_vec("w1_data", o_Write_Data, 32'hBEEF);
        i_Write_Grant = 1'b1;
        tick();
        i_Write_Grant = 1'b0;
        check_vec("w1_empty", o_Write_Request, 0);
        check_vec("w1_err", o_Protocol_Error, 0);

        // fill write FIFO
        for (int k = 0; k < 8; k++) begin
            check_vec("fill_rdy", o_Wr_Ready, 1);
            i_Wr_Valid = 1'b1; i_Wr_Address = 20'h00100 + 20'(k); i_Wr_Data = 16'hA000 + 16'(k);
            tick();
        end
        i_Wr_Address = 20'h00108; i_Wr_Data = 16'hA008;
        check_vec("full_rdy", o_Wr_Ready, 0);
        check_vec("full_head", o_Write_Address, 32'h00100);
        tick();
        check_vec("held_rdy", o_Wr_Ready, 0);
        i_Write_Grant = 1'b1;
        tick();
        check_vec("after_grant_rdy", o_Wr_Ready, 1);
        for (int k = 1; k <= 8; k++) begin
            check_vec("drain_addr", o_Write_Address, 32'h00100 + k);
            check_vec("drain_data", o_Write_Data, 32'hA000 + k);
            tick();
            i_Wr_Valid = 1'b0;
        end
        i_Write_Grant = 1'b0;
        check_vec("drain_empty", o_Write_Request, 0);

        // read-after-write hazard
        i_Wr_Valid = 1'b1; i_Wr_Address = 20'h00050; i_Wr_Data = 16'h1234;
        tick();
        i_Wr_Valid = 1'b0;
        i_Rd_Valid = 1'b1; i_Rd_Address = 20'h00050;
        tick();
        i_Rd_Valid = 1'b0;
        check_vec("haz_rreq0", o_Read_Request, 0);
        tick();
        check_vec("haz_rreq1", o_Read_Request, 0);
        check_vec("haz_wreq", o_Write_Request, 1);
        i_Write_Grant = 1'b1;
        tick();
        i_Write_Grant = 1'b0;
        check_vec("haz_clear_rreq", o_Read_Request, 1);
        check_vec("haz_raddr", o_Read_Address, 32'h00050);
        i_Read_Grant = 1'b1;
        tick();
        i_Read_Grant = 1'b0;
        check_vec("haz_outst", o_Rd_Outstanding, 1);
        i_Data_Valid = 1'b1; i_Read_Data = 16'h5555; i_Rd_Data_Ready = 1'b1;
        tick();
        i_Data_Valid = 1'b0;
        check_vec("haz_rdv", o_Rd_Data_Valid, 1);
        check_vec("haz_rdata", o_Rd_Data, 32'h5555);
        check_vec("haz_outst0", o_Rd_Outstanding, 0);
        tick();
        check_vec("haz_ret_empty", o_Rd_Data_Valid, 0);

        // different address is not blocked
        i_Wr_Valid = 1'b1; i_Wr_Address = 20'h00050; i_Wr_Data = 16'h4321;
        i_Rd_Valid = 1'b1; i_Rd_Address = 20'h00051;
        tick();
        i_Wr_Valid = 1'b0; i_Rd_Valid = 1'b0;
        check_vec("nohaz_rreq", o_Read_Request, 1);
        check_vec("nohaz_wreq", o_Write_Request, 1);
        i_Read_Grant = 1'b1;
        tick();
        i_Read_Grant = 1'b0;
        i_Write_Grant = 1'b1; i_Data_Valid = 1'b1; i_Read_Data = 16'h5151;
        tick();
        i_Write_Grant = 1'b0; i_Data_Valid = 1'b0;
        check_vec("nohaz_rdata", o_Rd_Data, 32'h5151);
        check_vec("nohaz_outst", o_Rd_Outstanding, 0);
        check_vec("nohaz_wempty", o_Write_Request, 0);
        tick();
        i_Rd_Data_Ready = 1'b0;
        check_vec("nohaz_err", o_Protocol_Error, 0);

        // credit limit with stalled client
        pushed = 0; grants = 0; returns = 0; consumed = 0;
        for (int cyc = 0; cyc < 120; cyc++) begin
            check_vec("cr_outst", o_Rd_Outstanding, grants - returns);
            check_vec("cr_limit", (int'(o_Rd_Outstanding) + returns - consumed) <= 8, 1);
            if (cyc == 60) check_vec("cr_grants_stalled", grants, 8);
            i_Rd_Data_Ready = (cyc >= 60);
            if (i_Rd_Data_Ready && o_Rd_Data_Valid) begin
                check_vec("cr_order", o_Rd_Data, consumed + 1);
                consumed++;
            end
            i_Rd_Valid = (pushed < 10);
            i_Rd_Address = 20'h00200 + 20'(pushed);
            if (i_Rd_Valid && o_Rd_Ready) pushed++;
            i_Read_Grant = o_Read_Request;
            if (o_Read_Request) begin
                grants++;
                due.push_back(cyc + 4);
            end
            i_Data_Valid = 1'b0;
            if (due.size() > 0 && due[0] == cyc) begin
                void'(due.pop_front());
                returns++;
                i_Data_Valid = 1'b1;
                i_Read_Data = 16'(returns);
            end
            tick();
        end
        i_Rd_Valid = 1'b0; i_Read_Grant = 1'b0; i_Data_Valid = 1'b0;
        check_vec("cr_grants", grants, 10);
        check_vec("cr_consumed", consumed, 10);
        check_vec("cr_err", o_Protocol_Error, 0);

        // grant and data strobe in the same cycle
        i_Rd_Data_Ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_Rd_Valid = 1'b1; i_Rd_Address = 20'h00300 + 20'(k);
            tick();
        end
        i_Rd_Valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_vec("sc_rreq", o_Read_Request, 1);
            i_Read_Grant = 1'b1;
            tick();
        end
        i_Read_Grant = 1'b0;
        check_vec("sc_outst3", o_Rd_Outstanding, 3);
        check_vec("sc_rdv0", o_Rd_Data_Valid, 0);
        i_Read_Grant = 1'b1; i_Data_Valid = 1'b1; i_Read_Data = 16'h0AAA;
        tick();
        i_Read_Grant = 1'b0; i_Data_Valid = 1'b0;
        check_vec("sc_outst_same", o_Rd_Outstanding, 3);
        check_vec("sc_rdv1", o_Rd_Data_Valid, 1);
        check_vec("sc_rdata", o_Rd_Data, 32'h0AAA);
        i_Rd_Data_Ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_Data_Valid = 1'b1; i_Read_Data = 16'h0BB0 + 16'(k);
            tick();
        end
        i_Data_Valid = 1'b0;
        tick(); tick();
        check_vec("sc_outst0", o_Rd_Outstanding, 0);
        check_vec("sc_ret_empty", o_Rd_Data_Valid, 0);
        check_vec("sc_err", o_Protocol_Error, 0);
        i_Rd_Data_Ready = 1'b0;

        // protocol errors
        i_Data_Valid = 1'b1; i_Read_Data = 16'hDEAD;
        tick();
        i_Data_Valid = 1'b0;
        check_vec("err_dv", o_Protocol_Error, 1);
        check_vec("err_dv_dropped", o_Rd_Data_Valid, 0);
        tick();
        check_vec("err_sticky", o_Protocol_Error, 1);
        i_Reset_n = 1'b0;
        #1;
        check_vec("err_async_clr", o_Protocol_Error, 0);
        check_vec("err_rst_rdy", o_Wr_Ready, 0);
        @(negedge clk);
        i_Reset_n = 1'b1;
        tick();
        i_Read_Grant = 1'b1;
        tick();
        i_Read_Grant = 1'b0;
        check_vec("err_grant", o_Protocol_Error, 1);
        check_vec("err_grant_outst", o_Rd_Outstanding, 0);
        tick();
        check_vec("err_grant_held", o_Protocol_Error, 1);
        i_Reset_n = 1'b0;
        #1;
        check_vec("err_async_clr2", o_Protocol_Error, 0);
        @(negedge clk);
        i_Reset_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/sdram_client_port.md
Name: sdram_client_port

Overview:
- Client-side front end that sits directly upstream of the SDRAM controller.
- Buffers client write commands (address + data) and read commands in separate FIFOs, and drives the controller's request/grant interface from the FIFO heads.
- Collects controller read data into a return FIFO with valid/ready backpressure to the client.
- Enforces read-after-write ordering, since the controller always gives reads priority over writes.

Parameters:
- ADDRESS_SIZE, 20, width of word addresses ({bank, row, column}).
- DATA_SIZE, 16, width of data words.
- WR_DEPTH, 8, write FIFO entries; power of 2, ≥2.
- RD_DEPTH, 8, read-command FIFO entries; power of 2, ≥2.
- RET_DEPTH, 8, read-return FIFO entries; power of 2, ≥2; also the read credit limit.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- i_Reset_n  in  1  asynchronous, active-low reset.
- i_Wr_Valid  in  1  client write command valid.
- o_Wr_Ready  out  1  write FIFO can accept.
- i_Wr_Address  in  ADDRESS_SIZE  write address.
- i_Wr_Data  in  DATA_SIZE  write data.
- i_Rd_Valid  in  1  client read command valid.
- o_Rd_Ready  out  1  read-command FIFO can accept.
- i_Rd_Address  in  ADDRESS_SIZE  read address.
- o_Rd_Data_Valid  out  1  return data available.
- i_Rd_Data_Ready  in  1  client takes return data.
- o_Rd_Data  out  DATA_SIZE  return data (head of return FIFO).
- o_Read_Request  out  1  to controller.
- o_Read_Address  out  ADDRESS_SIZE  to controller.
- i_Read_Grant  in  1  from controller; combinational in request cycle.
- o_Write_Request  out  1  to controller.
- o_Write_Address  out  ADDRESS_SIZE  to controller.
- o_Write_Data  out  DATA_SIZE  to controller; valid in the grant cycle.
- i_Write_Grant  in  1  from controller.
- i_Data_Valid  in  1  controller read data strobe.
- i_Read_Data  in  DATA_SIZE  controller read data.
- o_Rd_Outstanding  out  clog2(RET_DEPTH)+1  granted reads not yet returned.
- o_Protocol_Error  out  1  sticky error flag.

Behaviour:
- Reset:
  - Async on i_Reset_n low: all FIFO pointers and counts cleared, outstanding counter = 0, o_Protocol_Error = 0.
  - All valid, ready and request outputs go to 0 immediately.
  - Ready outputs rise on the first clk edge after reset is released.
  - FIFO storage RAM is not reset; data/address outputs are don't-care while not valid.
- Client handshakes:
  - Push when valid & ready. o_Wr_Ready = (wr count < WR_DEPTH); o_Rd_Ready = (rd count < RD_DEPTH).
  - Both readies are registered-state functions only; no same-cycle pass-through when full, even if a pop occurs that cycle.
- FIFOs:
  - Show-ahead: head entry drives the controller address/data outputs directly.
  - A pushed entry becomes visible at the head on the cycle after the push (1-cycle latency).
  - Simultaneous push and pop: count unchanged. Pointers wrap modulo depth.
- Write request: o_Write_Request = write FIFO non-empty. Pop on i_Write_Grant.
- Read request: o_Read_Request = read FIFO non-empty & !hazard & credit_ok.
  - credit_ok = (o_Rd_Outstanding + return count) < RET_DEPTH.
  - hazard = read-head address equals the address of any valid write FIFO entry (full ADDRESS_SIZE compare). The read waits until that write is granted.
  - Pop on i_Read_Grant; o_Rd_Outstanding increments on the same edge.
- Grant rules:
  - Grants are honoured only when the matching request is high. A grant with its request low is ignored and sets o_Protocol_Error.
  - Both requests may be high together; the controller picks. Both grants in one cycle sets o_Protocol_Error; both FIFOs pop.
- Return path:
  - On i_Data_Valid, push i_Read_Data into the return FIFO and decrement o_Rd_Outstanding. A grant and i_Data_Valid in the same cycle give net outstanding change 0.
  - o_Rd_Data_Valid = return FIFO non-empty. Pop on o_Rd_Data_Valid & i_Rd_Data_Ready.
  - Data returns in read-grant order.
  - The credit limit guarantees no overflow; zero client backpressure is never required.
  - i_Data_Valid with o_Rd_Outstanding = 0: data discarded, o_Protocol_Error set. This includes late data arriving after a mid-operation reset; reads in flight at reset are lost.
- o_Protocol_Error stays set until reset.
- Latency:
  - Client write accept → o_Write_Request high: 1 cycle.
  - i_Data_Valid → o_Rd_Data_Valid: 1 cycle.

Test Plan:
- Reset release, then write 0x00123 / 0xBEEF with grant tied high: o_Write_Request high 1 cycle after accept, o_Write_Address = 0x00123, o_Write_Data = 0xBEEF in the grant cycle; FIFO empty next cycle.
- Push 8 writes with i_Write_Grant low: o_Wr_Ready falls after the 8th; 9th held off; one grant → o_Wr_Ready high next cycle; entries drain in order.
- Write 0x00050 pending (grant low) then read 0x00050: o_Read_Request stays 0. Grant write → o_Read_Request = 1 next cycle. Read 0x00051 under the same conditions is issued immediately.
- Credit: i_Rd_Data_Ready = 0, issue 10 reads, return data 0x0001..0x0008 via i_Data_Valid 4 cycles after each grant: only 8 grants; o_Rd_Outstanding + count never exceeds 8. Release ready → data read out 0x0001..0x0008 in order, then the remaining 2 reads issue.
- Grant and i_Data_Valid in the same cycle with outstanding = 3: outstanding stays 3, return count +1.
- i_Data_Valid with outstanding = 0, then i_Read_Grant with o_Read_Request low: data dropped, o_Protocol_Error = 1 and held; an i_Reset_n pulse clears it asynchronously.
